// File: rtl/led_pattern_ctrl.sv
// Switch debounce, release-command decode and four-mode LED sequencer.
// mode       | meaning
// MODE_PASS  | LEDs follow debounced switches, registered
// MODE_CHASE | single lit LED rotates, direction selectable
// MODE_COUNT | 4-bit binary up/down counter on the LEDs
// MODE_BLINK | all LEDs invert each step
module led_pattern_ctrl #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int STEP_LIMIT     = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int DB_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int SC_W = (STEP_LIMIT > 1) ? $clog2(STEP_LIMIT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_LIMIT - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  logic [3:0]      sw_raw;
  logic [3:0]      sw_deb;
  logic [3:0]      sw_deb_d;
  logic [DB_W-1:0] db_cnt [4];
  logic [3:0]      cmd;

  mode_t           mode;
  mode_t           mode_next;
  logic [1:0]      mode_inc;
  logic            pause;
  logic            dir_up;
  logic [SC_W-1:0] step_cnt;
  logic            tick;
  logic [3:0]      pattern;
  logic [3:0]      pattern_step;

  logic            active;
  logic            run;
  logic            mode_cmd;
  logic            pause_cmd;
  logic            dir_cmd;
  logic            clr_cmd;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sw_deb   <= '0;
      sw_deb_d <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sw_deb_d <= sw_deb;
      for (int i = 0; i < 4; i++) begin
        if (sw_raw[i] != sw_deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            sw_deb[i] <= sw_raw[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A command is the release of a debounced switch.
  assign cmd       = sw_deb_d & ~sw_deb;
  assign active    = (mode != MODE_PASS);
  assign run       = active && !pause;
  assign mode_cmd  = cmd[0];
  assign pause_cmd = cmd[1] && active;
  assign dir_cmd   = cmd[2] && active;
  assign clr_cmd   = cmd[3] && active;

  assign mode_inc  = mode + 2'd1;
  assign mode_next = mode_t'(mode_inc);

  function automatic logic [3:0] init_pattern(input mode_t m, input logic [3:0] deb);
    case (m)
      MODE_PASS:  init_pattern = deb;
      MODE_CHASE: init_pattern = 4'b0001;
      default:    init_pattern = 4'b0000;
    endcase
  endfunction

  always_comb begin
    pattern_step = pattern;
    case (mode)
      MODE_CHASE: pattern_step = dir_up ? {pattern[2:0], pattern[3]}
                                        : {pattern[0], pattern[3:1]};
      MODE_COUNT: pattern_step = dir_up ? pattern + 4'd1 : pattern - 4'd1;
      MODE_BLINK: pattern_step = ~pattern;
      default:    pattern_step = pattern;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mode     <= MODE_PASS;
      pause    <= 1'b0;
      dir_up   <= 1'b1;
      step_cnt <= '0;
      tick     <= 1'b0;
      pattern  <= '0;
    end else if (mode_cmd) begin
      mode     <= mode_next;
      pause    <= 1'b0;
      step_cnt <= '0;
      tick     <= 1'b0;
      pattern  <= init_pattern(mode_next, sw_deb);
    end else if (clr_cmd) begin
      step_cnt <= '0;
      tick     <= 1'b0;
      pattern  <= init_pattern(mode, sw_deb);
    end else begin
      if (pause_cmd) pause  <= ~pause;
      if (dir_cmd)   dir_up <= ~dir_up;
      if (run) begin
        if (step_cnt == SC_LAST) begin
          step_cnt <= '0;
          tick     <= 1'b1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
          tick     <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
      // A pending tick is dropped when a toggle lands on it or a pause has begun.
      if (mode == MODE_PASS)
        pattern <= sw_deb;
      else if (tick && !pause && !pause_cmd && !dir_cmd)
        pattern <= pattern_step;
    end
  end

  assign o_LED_1 = pattern[0];
  assign o_LED_2 = pattern[1];
  assign o_LED_3 = pattern[2];
  assign o_LED_4 = pattern[3];
  assign o_Mode  = mode;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with short debounce and step periods.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sw1, sw2, sw3, sw4;
  logic       led1, led2, led3, led4;
  logic [1:0] mode;

  int pass_cnt = 0;
  int total    = 0;

  led_pattern_ctrl #(.DEBOUNCE_LIMIT(4), .STEP_LIMIT(8)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch_1 (sw1),
    .i_Switch_2 (sw2),
    .i_Switch_3 (sw3),
    .i_Switch_4 (sw4),
    .o_LED_1    (led1),
    .o_LED_2    (led2),
    .o_LED_3    (led3),
    .o_LED_4    (led4),
    .o_Mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sw;
    int         wait_n;
    logic [1:0] mode;
    logic [3:0] led;
    string      name;
  } vec_t;

  vec_t vec [8];

  function automatic logic [5:0] get_out();
    return {mode, led4, led3, led2, led1};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic set_sw(input int idx, input logic v);
    case (idx)
      1: sw1 = v;
      2: sw2 = v;
      3: sw3 = v;
      default: sw4 = v;
    endcase
  endtask

  // Called at a negedge; returns at the negedge right after the command edge (start + 10).
  task automatic cmd(input int idx);
    set_sw(idx, 1'b1);
    repeat (5) @(negedge clk);
    set_sw(idx, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] acc;

    // CHASE from entry edge E: steps land on E+9, E+17, E+25, E+33, E+41.
    vec[0] = '{1, 0, 2'd1, 4'b0001, "chase_enter"};
    vec[1] = '{0, 8, 2'd1, 4'b0001, "chase_before_step"};
    vec[2] = '{0, 1, 2'd1, 4'b0010, "chase_step1"};
    vec[3] = '{0, 7, 2'd1, 4'b0010, "chase_hold1"};
    vec[4] = '{0, 1, 2'd1, 4'b0100, "chase_step2"};
    vec[5] = '{0, 8, 2'd1, 4'b1000, "chase_step3"};
    vec[6] = '{0, 8, 2'd1, 4'b0001, "chase_wrap"};
    vec[7] = '{0, 8, 2'd1, 4'b0010, "chase_step5"};

    rst_n = 1'b0;
    sw1 = 1'b0; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", get_out(), 6'b00_0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", get_out(), 6'b00_0000);

    // PASS: LED_3 follows on the 5th edge after the raw change.
    sw3 = 1'b1;
    repeat (4) @(negedge clk);
    check("pass_led3_edge4", get_out(), 6'b00_0000);
    @(negedge clk);
    check("pass_led3_edge5", get_out(), 6'b00_0100);
    sw3 = 1'b0;
    repeat (5) @(negedge clk);
    check("pass_led3_release", get_out(), 6'b00_0000);

    // 3-cycle glitch never reaches the debounced state.
    sw2 = 1'b1;
    repeat (3) @(negedge clk);
    sw2 = 1'b0;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = acc | get_out();
    end
    check("glitch_sw2", acc, 6'b00_0000);

    for (int i = 0; i < 8; i++) begin
      if (vec[i].sw != 0) cmd(vec[i].sw);
      repeat (vec[i].wait_n) @(negedge clk);
      check(vec[i].name, get_out(), {vec[i].mode, vec[i].led});
    end

    // Pause lands at E+51, two edges after 0100 appeared (counter was 2 when it arrived).
    cmd(2);
    check("pause_enter", get_out(), 6'b01_0100);
    acc = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = acc | (get_out() ^ 6'b01_0100);
    end
    check("pause_hold40", acc, 6'b00_0000);
    cmd(2);
    repeat (5) @(negedge clk);
    check("resume_before_step", get_out(), 6'b01_0100);
    @(negedge clk);
    check("resume_step_8_minus_2", get_out(), 6'b01_1000);

    // Enter COUNT at M and toggle direction at M+2, before the first step.
    sw1 = 1'b1;
    repeat (2) @(negedge clk);
    sw3 = 1'b1;
    repeat (3) @(negedge clk);
    sw1 = 1'b0;
    repeat (2) @(negedge clk);
    sw3 = 1'b0;
    repeat (3) @(negedge clk);
    check("count_enter", get_out(), 6'b10_0000);
    repeat (8) @(negedge clk);
    check("count_before_step", get_out(), 6'b10_0000);
    @(negedge clk);
    check("count_down_wrap", get_out(), 6'b10_1111);
    repeat (8) @(negedge clk);
    check("count_down_step2", get_out(), 6'b10_1110);

    cmd(4);
    check("count_clear", get_out(), 6'b10_0000);
    repeat (8) @(negedge clk);
    check("clear_restart_hold", get_out(), 6'b10_0000);
    @(negedge clk);
    check("clear_restart_step", get_out(), 6'b10_1111);

    cmd(1);
    check("blink_enter", get_out(), 6'b11_0000);
    repeat (9) @(negedge clk);
    check("blink_step1", get_out(), 6'b11_1111);
    repeat (8) @(negedge clk);
    check("blink_step2", get_out(), 6'b11_0000);
    repeat (8) @(negedge clk);
    check("blink_step3", get_out(), 6'b11_1111);

    #2 rst_n = 1'b0;
    #1 check("async_reset", get_out(), 6'b00_0000);
    @(negedge clk);
    rst_n = 1'b1;

    sw4 = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_pass_edge4", get_out(), 6'b00_0000);
    @(negedge clk);
    check("post_reset_pass_led4", get_out(), 6'b00_1000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Controller for the board's 4 push-switches and 4 LEDs.
- Debounces each switch and decodes switch releases into commands.
- Sequences the LEDs through one of four display modes: passthrough, chase, binary count, blink.
- Sits between the raw board I/O pins and the LEDs, replacing direct switch-to-LED wiring.

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive cycles a raw switch must differ from its debounced state before that state updates (10 ms at 25 MHz).
STEP_LIMIT, 6250000, cycles between pattern steps (250 ms at 25 MHz).

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Rst_L  input  1  reset, asynchronous, active-low
i_Switch_1  input  1  raw switch, mode-select command
i_Switch_2  input  1  raw switch, pause/resume command
i_Switch_3  input  1  raw switch, direction-toggle command
i_Switch_4  input  1  raw switch, pattern-clear command
o_LED_1  output  1  LED, pattern bit 0
o_LED_2  output  1  LED, pattern bit 1
o_LED_3  output  1  LED, pattern bit 2
o_LED_4  output  1  LED, pattern bit 3
o_Mode  output  2  current mode: 0 PASS, 1 CHASE, 2 COUNT, 3 BLINK

Behaviour:
- Reset (i_Rst_L low, asynchronous):
  - All outputs 0; mode PASS; pause 0; direction up.
  - Debounced states 0; debounce and step counters 0.
- Debounce, per switch:
  - Counter increments each cycle raw != debounced; clears when raw == debounced.
  - When the counter equals DEBOUNCE_LIMIT-1 and raw still differs: debounced takes raw at the next edge and the counter clears.
  - Net effect: debounced changes on the DEBOUNCE_LIMIT-th edge after a stable change.
- Command = release edge (debounced 1->0), a 1-cycle internal pulse.
- Switch_1 command: mode advances PASS->CHASE->COUNT->BLINK->PASS.
  - On the same edge: step counter cleared, pause cleared, pattern loaded with mode initial value (CHASE 4'b0001, COUNT 4'b0000, BLINK 4'b0000).
  - Direction is retained across mode changes.
- Switch_2/3/4 commands are ignored in PASS mode.
- Switch_2 command: toggles pause. While paused the step counter holds its value; no steps occur.
- Switch_3 command: toggles direction.
- Switch_4 command: pattern reloads the current mode's initial value; step counter cleared.
- Step tick:
  - Step counter counts 0..STEP_LIMIT-1 when not paused and mode != PASS.
  - Tick is a 1-cycle pulse on the wrap edge.
  - Pattern updates on the edge after the tick.
- Pattern update per mode:
  - CHASE up: rotate left, LED_1->LED_2->LED_3->LED_4->LED_1. CHASE down: rotate right.
  - COUNT up: +1 mod 16 (15->0). COUNT down: -1 mod 16 (0->15).
  - BLINK: invert all 4 bits, independent of direction.
- PASS mode: o_LED_n = debounced i_Switch_n, registered (one cycle after the debounced update).
- LED outputs and o_Mode are registered; no combinational path from inputs.
- Priority within one cycle:
  - Mode change > clear > pause/direction toggles > step tick.
  - A dropped lower-priority command is lost, not queued.
  - Commands from different switches below mode change may coexist, e.g. direction toggle and pause in the same cycle both apply.
- Reset mid-sequence: immediate return to reset state; no partial step completes.

Test Plan:
Bench parameters: DEBOUNCE_LIMIT=4, STEP_LIMIT=8.
1. After reset, in PASS, raise i_Switch_3 and hold -> o_LED_3 rises on the 5th rising edge after the input change; other LEDs stay 0; o_Mode=0.
2. In PASS, 3-cycle high glitch on i_Switch_2 -> debounced state and o_LED_2 unchanged (0).
3. Press then release i_Switch_1 -> o_Mode=1, LEDs=4'b0001. Subsequent steps every 8 cycles: 0010, 0100, 1000, 0001 (wrap).
4. Advance to COUNT, release i_Switch_3 -> LEDs step 0000->1111->1110. Release i_Switch_4 -> LEDs=0000 and step counter restarts from 0.
5. In CHASE at LEDs=0100, release i_Switch_2 -> LEDs hold for 40 cycles. Release again -> next step (1000) occurs exactly (8 - counter value at pause) cycles later.
6. In BLINK after several toggles, drive i_Rst_L low asynchronously between clock edges -> all LEDs 0 and o_Mode=0 before the next edge. Release reset -> PASS behaviour resumes.
